// File: rtl/timer_seg_scan_pkg.sv
// Shared constants for the timer display scanner: segment patterns, slot encoding, anode masks.
// All patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] SLOT_SEC0 = 2'd0;
  localparam logic [1:0] SLOT_SEC1 = 2'd1;
  localparam logic [1:0] SLOT_MIN0 = 2'd2;
  localparam logic [1:0] SLOT_MIN1 = 2'd3;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low anode select for a scan slot.
  function automatic logic [3:0] an_select(input logic [1:0] slot);
    return ~(4'b0001 << slot);
  endfunction

endpackage

// File: rtl/timer_seg_scan_if.sv
// Digit/status inputs from the timer control FSM and the multiplexed display drive outputs.
// master: the side that supplies digits and observes the display; slave: the scanner.
interface timer_seg_scan_if;

  logic [3:0] min_1;
  logic [3:0] min_0;
  logic [3:0] sec_1;
  logic [3:0] sec_0;
  logic       alarm;
  logic       paused;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output min_1, min_0, sec_1, sec_0, alarm, paused,
    input  an, seg, dp
  );

  modport slave (
    input  min_1, min_0, sec_1, sec_0, alarm, paused,
    output an, seg, dp
  );

endinterface

// File: rtl/timer_seg_scan_bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal codes render as a dash.
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/timer_seg_scan.sv
// Four-digit common-anode display scanner with per-frame digit snapshot, alarm blink and pause dp.
// Define SEG_LZB_EN to blank a leading zero in the minutes-tens position.
module timer_seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 128
) (
  input  logic             clock,
  input  logic             reset,
  timer_seg_scan_if.slave  disp_io
);

  localparam int unsigned PrescW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(SCAN_DIV - 1);
  localparam logic [FrameW-1:0] FrameMax = FrameW'(BLINK_FRAMES - 1);

  logic [PrescW-1:0] presc_q, presc_d;
  logic [1:0]        slot_q, slot_d;
  logic [3:0][3:0]   shadow_q, shadow_d;
  logic [FrameW-1:0] frame_q, frame_d;
  logic              blink_q, blink_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic       tick;
  logic       frame_end;
  logic [3:0] cur_digit;
  logic [6:0] cur_seg;

  assign tick      = (presc_q == PrescMax);
  assign frame_end = tick && (slot_q == SLOT_MIN1);
  assign cur_digit = shadow_q[slot_q];

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (cur_seg)
  );

  // Scan timing, snapshot and blink counters.
  always_comb begin
    presc_d  = tick ? '0 : presc_q + PrescW'(1);
    slot_d   = tick ? slot_q + 2'd1 : slot_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    blink_d  = blink_q;
    if (frame_end) begin
      shadow_d = {disp_io.min_1, disp_io.min_0, disp_io.sec_1, disp_io.sec_0};
      if (frame_q == FrameMax) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + FrameW'(1);
      end
    end
  end

  // Display drive for the slot currently selected; lands on the pins one cycle later.
  always_comb begin
    an_d  = an_select(slot_q);
    seg_d = cur_seg;
    dp_d  = !((slot_q == SLOT_MIN0) && (!disp_io.paused || !blink_q));
`ifdef SEG_LZB_EN
    if ((slot_q == SLOT_MIN1) && (shadow_q[SLOT_MIN1] == 4'd0)) begin
      an_d = AN_OFF;
    end
`endif
    // Alarm blanking wins over the pause dp blink.
    if (disp_io.alarm && blink_q) begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q  <= '0;
      slot_q   <= SLOT_SEC0;
      shadow_q <= '0;
      frame_q  <= '0;
      blink_q  <= 1'b0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
    end else begin
      presc_q  <= presc_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      blink_q  <= blink_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign disp_io.an  = an_q;
  assign disp_io.seg = seg_q;
  assign disp_io.dp  = dp_q;

endmodule

// File: tb/tb_timer_seg_scan.sv
// Directed bench for timer_seg_scan: time-indexed reference model checked every cycle,
// plus hand-computed literal expectations at chosen cycles.
module tb_timer_seg_scan;

  localparam int unsigned D        = 4;
  localparam int unsigned B        = 2;
  localparam int unsigned FrameLen = 4 * D;

  localparam logic [6:0] SegTbl [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  timer_seg_scan_if bus ();

  timer_seg_scan #(
    .SCAN_DIV     (D),
    .BLINK_FRAMES (B)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .disp_io (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int tm       = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", name, tm, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    if (d < 4'd10) return SegTbl[int'(d)];
    return 7'b0111111;
  endfunction

  // Reference model: state derived from the number of edges since reset release.
  int         t = 0;
  logic [3:0] m_shadow [4];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;
  bit         exp_valid = 0;

  initial begin
    int  k;
    int  slot;
    int  frames;
    bit  blink;
    forever begin
      @(posedge clock);
      if (reset) begin
        t = 0;
        for (int i = 0; i < 4; i++) m_shadow[i] = 4'd0;
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end else begin
        t++;
        k      = t - 1;
        slot   = (k / D) % 4;
        frames = k / FrameLen;
        blink  = ((frames / B) % 2) == 1;
        exp_an  = ~(4'b0001 << slot);
        exp_seg = ref_seg(m_shadow[slot]);
        exp_dp  = !(slot == 2 && (!bus.paused || !blink));
`ifdef SEG_LZB_EN
        if (slot == 3 && m_shadow[3] == 4'd0) exp_an = 4'hF;
`endif
        if (bus.alarm && blink) begin
          exp_an  = 4'hF;
          exp_seg = 7'h7F;
          exp_dp  = 1'b1;
        end
        if (t % FrameLen == 0) begin
          m_shadow[0] = bus.sec_0;
          m_shadow[1] = bus.sec_1;
          m_shadow[2] = bus.min_0;
          m_shadow[3] = bus.min_1;
        end
      end
      exp_valid = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (exp_valid) begin
        check("model_an", 32'(bus.an), 32'(exp_an));
        check("model_seg", 32'(bus.seg), 32'(exp_seg));
        check("model_dp", 32'(bus.dp), 32'(exp_dp));
      end
    end
  end

  task automatic wait_to(input int target);
    while (tm < target) begin
      @(negedge clock);
      tm++;
    end
  endtask

  task automatic lit(input string name, input logic [3:0] an, input logic [6:0] seg,
                     input logic dp);
    check({name, "_an"}, 32'(bus.an), 32'(an));
    check({name, "_seg"}, 32'(bus.seg), 32'(seg));
    check({name, "_dp"}, 32'(bus.dp), 32'(dp));
  endtask

  initial begin
    bus.min_1  = 4'd0;
    bus.min_0  = 4'd0;
    bus.sec_1  = 4'd0;
    bus.sec_0  = 4'd0;
    bus.alarm  = 1'b0;
    bus.paused = 1'b0;
    reset      = 1'b1;
    repeat (3) @(negedge clock);
    lit("reset", 4'b1111, 7'h7F, 1'b1);

    bus.min_1 = 4'd1;
    bus.min_0 = 4'd2;
    bus.sec_1 = 4'd3;
    bus.sec_0 = 4'd4;
    reset     = 1'b0;
    tm        = 0;

    wait_to(1);   lit("first_slot", 4'b1110, 7'b1000000, 1'b1);
    wait_to(17);  lit("f2_sec0", 4'b1110, 7'b0011001, 1'b1);
    wait_to(20);  check("slot0_len", 32'(bus.an), 32'(4'b1110));
    wait_to(21);  lit("f2_sec1", 4'b1101, 7'b0110000, 1'b1);
    wait_to(25);  lit("f2_min0", 4'b1011, 7'b0100100, 1'b0);
    wait_to(29);  lit("f2_min1", 4'b0111, 7'b1111001, 1'b1);

    // sec_0 changes while slot 1 is on; seen only after the frame boundary.
    wait_to(37);  bus.sec_0 = 4'd7;
    wait_to(48);  lit("pre_snap", 4'b0111, 7'b1111001, 1'b1);
    wait_to(49);  lit("post_snap", 4'b1110, 7'b1111000, 1'b1);

    wait_to(64);  bus.alarm = 1'b1;
    wait_to(70);  lit("alarm_on", 4'b1101, 7'b0110000, 1'b1);
    wait_to(100); lit("alarm_off", 4'b1111, 7'h7F, 1'b1);
    wait_to(105); bus.alarm = 1'b0;
    wait_to(106); lit("alarm_drop", 4'b1011, 7'b0100100, 1'b0);

    wait_to(112); bus.sec_1 = 4'hC; bus.paused = 1'b1;
    wait_to(133); lit("dash", 4'b1101, 7'b0111111, 1'b1);
    wait_to(137); check("pause_dp_on", 32'(bus.dp), 32'(1'b0));
    wait_to(169); check("pause_dp_off", 32'(bus.dp), 32'(1'b1));
    wait_to(201); check("pause_dp_on2", 32'(bus.dp), 32'(1'b0));

    wait_to(210); bus.alarm = 1'b1;
    wait_to(233); lit("alarm_pause", 4'b1111, 7'h7F, 1'b1);
    wait_to(240); bus.alarm = 1'b0; bus.min_1 = 4'd0; bus.paused = 1'b0;
`ifdef SEG_LZB_EN
    wait_to(269); lit("lzb", 4'b1111, 7'b1000000, 1'b1);
`else
    wait_to(269); lit("no_lzb", 4'b0111, 7'b1000000, 1'b1);
`endif

    wait_to(278); reset = 1'b1;
    @(negedge clock);
    lit("mid_reset", 4'b1111, 7'h7F, 1'b1);
    reset = 1'b0;
    tm    = 0;
    wait_to(1);   lit("restart", 4'b1110, 7'b1000000, 1'b1);
    wait_to(40);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
